vin_ddr_burst_writer: RTL and testbench
=======================================

Name: vin_ddr_burst_writer

Overview:
- Parametrised successor to the single-channel laser-data DDR write buffer in the acc-dump path.
- Buffers frame-gated input beats in an internal FWFT FIFO and issues fixed-length DDR write bursts to a line-indexed address ring.
- Flushes the partial last burst at frame end with its true length; the previous generation dropped the residue.
- Sits between the laser acquisition front end and the DDR write arbiter. Single clock domain: ddr_clk_i.

Parameters:
- ADDR_WIDTH, 30: DDR address width.
- MEM_DATA_BITS, 256: input and DDR data width; one beat = one FIFO word.
- FIFO_DEPTH, 512: buffer depth in words; power of two, ≥ 2*BURST_LEN.
- BURST_LEN, 128: full burst length in beats, 1..255.
- BASE_ADDR, 30'h1100_0000: ring base address.
- LINE_SHIFT, 8: address increment per burst = 1 << LINE_SHIFT.
- LINE_NUM, 65536: ring size in bursts; line index wraps to 0 after LINE_NUM-1.

Ports:
- ddr_clk_i  in  1  clock.
- ddr_rst_n_i  in  1  asynchronous active-low reset.
- laser_start_i  in  1  frame gate: rising edge starts a frame, falling edge ends it.
- laser_vld_i  in  1  input beat strobe.
- laser_data_i  in  MEM_DATA_BITS  input beat.
- wr_ddr_req_o  out  1  burst request.
- wr_ddr_len_o  out  8  burst length in beats.
- wr_ddr_addr_o  out  ADDR_WIDTH  burst start address.
- ddr_fifo_rd_req_i  in  1  DDR pulls one beat.
- wr_ddr_data_o  out  MEM_DATA_BITS  FIFO head, FWFT.
- wr_ddr_finish_i  in  1  burst complete pulse.
- frame_done_o  out  1  one-cycle pulse when a frame is fully written and the FIFO cleared.
- frame_lines_o  out  16  bursts written in the last completed frame; held until next frame_done_o.

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0. State IDLE. FIFO empty. Line index 0.
- Input sync: laser_start_i passes through 2 flops. Edge detect on the synchronised pair.
- FIFO write: laser_vld_i writes only while the frame is active (between start rise and the end-detect cycle). A write when full is dropped. Beats are never overwritten.
- FIFO read: ddr_fifo_rd_req_i pops. A pop when empty is ignored and data is unchanged. Fill count is exact; simultaneous push+pop leaves it unchanged.
- State machine:
  - IDLE: on start edge, line := 0, go to WAIT.
  - WAIT: if fill ≥ BURST_LEN, go to REQ with len := BURST_LEN. Else if frame_end seen and fill > 0, go to REQ with len := fill. Else if frame_end seen and fill = 0, go to CLEAR.
  - REQ: 1 cycle; assert wr_ddr_req_o and latch the address. Go to BURSTING.
  - BURSTING: on wr_ddr_finish_i, line := (line+1) mod LINE_NUM, then back to WAIT.
  - CLEAR: 32 cycles, then pulse frame_done_o, update frame_lines_o, go to IDLE.
- frame_end is sticky from the falling edge until CLEAR is entered. A falling edge arriving while BURSTING is honoured after that burst.
- A start edge outside IDLE is ignored.
- Address: wr_ddr_addr_o = BASE_ADDR + (line << LINE_SHIFT), registered in REQ, stable through BURSTING. Arithmetic is truncated to ADDR_WIDTH.
- wr_ddr_req_o: set on the cycle entering BURSTING. Cleared on the first ddr_fifo_rd_req_i, on wr_ddr_finish_i, or in IDLE.
- wr_ddr_len_o: registered; changes only on REQ entry.
- Partial length is frozen at REQ. Beats arriving afterwards stay for a later burst. No more than len beats are guaranteed present when requested.
- Latency: first request issues 2 cycles after fill reaches BURST_LEN.
- Wrap: after line LINE_NUM-1, the next burst targets BASE_ADDR.
- ddr_rst_n_i low mid-burst: everything returns to reset state immediately. The arbiter is responsible for aborting its side.

Optional Feature:
- Macro: VIN_OVERFLOW_STAT_EN.
- Defined:
  - Adds output ports ovf_flag_o (1 bit, sticky) and ovf_cnt_o (16 bits, saturating). Both count input beats dropped on a full FIFO.
  - Both clear on a start edge in IDLE and on reset.
- Not defined: ports absent, no counter logic, drop behaviour unchanged.

Test Plan:
- Full bursts: BURST_LEN=128; frame of 256 continuous beats then start falls -> two requests, len 128, addr 0x1100_0000 then 0x1100_0100; frame_done_o pulses; frame_lines_o=2.
- Partial flush: 300 beats -> bursts of 128, 128, 44; third addr 0x1100_0200; frame_lines_o=3.
- Empty frame: start pulse with no vld -> no request; frame_done_o after CLEAR; frame_lines_o=0.
- Wrap: LINE_NUM=4, 5 full bursts -> fifth addr = BASE_ADDR.
- Overflow (macro on): FIFO_DEPTH=512, DDR stalled, 520 beats -> ovf_cnt_o=8, ovf_flag_o=1; first 512 beats written in order.
- Reset mid-burst: ddr_rst_n_i low during BURSTING -> req/len/addr=0 asynchronously; next frame starts at line 0 with empty FIFO.

Source files
------------

// File: rtl/vin_ddr_burst_writer.sv
// Frame-gated FWFT FIFO feeding fixed-length DDR write bursts into a line-indexed address ring.
// Optional drop statistics are enabled with `define VIN_OVERFLOW_STAT_EN.
module vin_ddr_burst_writer #(
  parameter int                    ADDR_WIDTH    = 30,
  parameter int                    MEM_DATA_BITS = 256,
  parameter int                    FIFO_DEPTH    = 512,
  parameter int                    BURST_LEN     = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 30'h1100_0000,
  parameter int                    LINE_SHIFT    = 8,
  parameter int                    LINE_NUM      = 65536
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     laser_start_i,
  input  logic                     laser_vld_i,
  input  logic [MEM_DATA_BITS-1:0] laser_data_i,
  output logic                     wr_ddr_req_o,
  output logic [7:0]               wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
  input  logic                     ddr_fifo_rd_req_i,
  output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
  input  logic                     wr_ddr_finish_i,
  output logic                     frame_done_o,
  output logic [15:0]              frame_lines_o
`ifdef VIN_OVERFLOW_STAT_EN
  ,
  output logic                     ovf_flag_o,
  output logic [15:0]              ovf_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LINE_W = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
  localparam logic [PTR_W:0] FULL_CNT  = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] BURST_CNT = BURST_LEN[PTR_W:0];

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_BURST, S_CLEAR} state_t;

  state_t state, state_next;
  logic [1:0] rst_sync;
  logic rst_int_n;
  logic start_p0, start_p1, start_p2;
  logic start_rise, start_fall;
  logic frame_active, frame_end;
  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] fill;
  logic push, pop, full;
  logic [LINE_W-1:0] line;
  logic [15:0] burst_cnt;
  logic [4:0] clr_cnt;
  logic frame_start;

  // Reset asserts immediately but releases on the clock.
  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // ---- stage: frame gate synchroniser and edge detect
  always_ff @(posedge ddr_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
    end else begin
      start_p0 <= laser_start_i;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
    end
  end
  assign start_rise  = start_p1 & ~start_p2;
  assign start_fall  = ~start_p1 & start_p2;
  assign frame_start = (state == S_IDLE) && start_rise;

  // ---- stage: FWFT FIFO
  assign full = (fill == FULL_CNT);
  assign push = laser_vld_i & frame_active & ~full;
  assign pop  = ddr_fifo_rd_req_i & (fill != '0);

  always_ff @(posedge ddr_clk_i) begin
    if (push) mem[wr_ptr] <= laser_data_i;
  end

  always_ff @(posedge ddr_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fill <= fill + (PTR_W+1)'(1);
      else if (pop && !push) fill <= fill - (PTR_W+1)'(1);
    end
  end

  // Empty FIFO presents zero so the output is defined out of reset.
  assign wr_ddr_data_o = (fill == '0) ? '0 : mem[rd_ptr];

  // ---- stage: burst control FSM
  always_ff @(posedge ddr_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_rise) state_next = S_WAIT;
      S_WAIT: begin
        if (fill >= BURST_CNT)              state_next = S_REQ;
        else if (frame_end && fill != '0)   state_next = S_REQ;
        else if (frame_end)                 state_next = S_CLEAR;
      end
      S_REQ:   state_next = S_BURST;
      S_BURST: if (wr_ddr_finish_i) state_next = S_WAIT;
      S_CLEAR: if (clr_cnt == '1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frame_active  <= 1'b0;
      frame_end     <= 1'b0;
      wr_ddr_req_o  <= 1'b0;
      wr_ddr_len_o  <= '0;
      wr_ddr_addr_o <= '0;
      line          <= '0;
      burst_cnt     <= '0;
      clr_cnt       <= '0;
      frame_done_o  <= 1'b0;
      frame_lines_o <= '0;
    end else begin
      if (frame_start)     frame_active <= 1'b1;
      else if (start_fall) frame_active <= 1'b0;

      // Sticky end marker; a fall during a burst is picked up back in WAIT.
      if (state == S_IDLE || (state == S_WAIT && state_next == S_CLEAR)) frame_end <= 1'b0;
      else if (start_fall) frame_end <= 1'b1;

      if (state == S_WAIT && state_next == S_REQ)
        wr_ddr_len_o <= (fill >= BURST_CNT) ? BURST_LEN[7:0] : 8'(fill);

      if (state == S_REQ)
        wr_ddr_addr_o <= BASE_ADDR + (ADDR_WIDTH'(line) << LINE_SHIFT);

      if (state == S_REQ) wr_ddr_req_o <= 1'b1;
      else if (state == S_IDLE || ddr_fifo_rd_req_i || wr_ddr_finish_i) wr_ddr_req_o <= 1'b0;

      if (frame_start) begin
        line      <= '0;
        burst_cnt <= '0;
      end else if (state == S_BURST && wr_ddr_finish_i) begin
        line      <= (line == LINE_W'(LINE_NUM - 1)) ? '0 : line + LINE_W'(1);
        burst_cnt <= burst_cnt + 16'd1;
      end

      clr_cnt      <= (state == S_CLEAR) ? clr_cnt + 5'd1 : 5'd0;
      frame_done_o <= (state == S_CLEAR) && (clr_cnt == '1);
      if (state == S_CLEAR && clr_cnt == '1) frame_lines_o <= burst_cnt;
    end
  end

`ifdef VIN_OVERFLOW_STAT_EN
  logic drop;
  assign drop = laser_vld_i & frame_active & full;

  always_ff @(posedge ddr_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ovf_flag_o <= 1'b0;
      ovf_cnt_o  <= '0;
    end else if (frame_start) begin
      ovf_flag_o <= 1'b0;
      ovf_cnt_o  <= '0;
    end else if (drop) begin
      ovf_flag_o <= 1'b1;
      if (ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end
`else
  // Beats arriving on a full FIFO are discarded without record.
`endif

endmodule

// File: tb/tb_vin_ddr_burst_writer.sv
// Scoreboard bench for vin_ddr_burst_writer: expected bursts and beats are queued at stimulus
// time and checked by a DDR-side model as the DUT issues requests and presents data.
module tb_vin_ddr_burst_writer;
  localparam int AW = 30, DW = 256, DEPTH = 512, BL = 128, LN = 4;
  localparam logic [AW-1:0] BASE = 30'h1100_0000;

  typedef struct packed {
    logic [7:0]    len;
    logic [AW-1:0] addr;
  } burst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, vld = 1'b0, rd_req = 1'b0, finish = 1'b0;
  logic [DW-1:0] din = '0;
  logic req, done;
  logic [7:0] len;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic [15:0] lines;
`ifdef VIN_OVERFLOW_STAT_EN
  logic ovf_flag;
  logic [15:0] ovf_cnt;
`endif

  logic [DW-1:0] data_q[$];
  burst_t burst_q[$];
  int n_checks = 0, n_fail = 0;
  bit stall = 1'b0;
  burst_t cur;
  int blen;

  vin_ddr_burst_writer #(
    .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL),
    .BASE_ADDR(BASE), .LINE_SHIFT(8), .LINE_NUM(LN)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .laser_start_i(start), .laser_vld_i(vld),
    .laser_data_i(din), .wr_ddr_req_o(req), .wr_ddr_len_o(len), .wr_ddr_addr_o(addr),
    .ddr_fifo_rd_req_i(rd_req), .wr_ddr_data_o(dout), .wr_ddr_finish_i(finish),
    .frame_done_o(done), .frame_lines_o(lines)
`ifdef VIN_OVERFLOW_STAT_EN
    , .ovf_flag_o(ovf_flag), .ovf_cnt_o(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic push_bursts(input int nbeats);
    burst_t b;
    int rem, ln;
    rem = nbeats;
    ln = 0;
    while (rem > 0) begin
      b.len  = (rem >= BL) ? 8'(BL) : 8'(rem);
      b.addr = BASE + AW'((ln % LN) << 8);
      burst_q.push_back(b);
      rem -= int'(b.len);
      ln++;
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lines);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_lines"}, lines, exp_lines);
    chk({tag, "_bursts_left"}, burst_q.size(), 0);
    chk({tag, "_beats_left"}, data_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_frame(input string tag, input int nbeats, input int exp_lines, input bit gaps);
    logic [DW-1:0] d;
    push_bursts(nbeats);
    start = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        vld = 1'b0;
        @(negedge clk);
      end
      d = rand_word();
      vld = 1'b1;
      din = d;
      data_q.push_back(d);
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(tag, exp_lines);
  endtask

  // DDR arbiter model: serve each request, check descriptor and every beat in order.
  initial begin : ddr_model
    forever begin
      @(negedge clk);
      if (rst_n && req && !stall) begin
        chk("req_expected", burst_q.size() != 0, 1);
        cur = (burst_q.size() != 0) ? burst_q.pop_front() : '{len: len, addr: addr};
        chk("burst_len", len, cur.len);
        chk("burst_addr", addr, cur.addr);
        blen = int'(len);
        for (int i = 0; i < blen; i++) begin
          chk("beat_expected", data_q.size() != 0, 1);
          if (data_q.size() != 0) chk("beat_data", dout, data_q.pop_front());
          rd_req = 1'b1;
          @(negedge clk);
          if (i == 0) chk("req_clear_on_pop", req, 0);
        end
        rd_req = 1'b0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] d;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_len", len, 0);
    chk("rst_addr", addr, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines, 0);
    chk("rst_data", dout, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("full", 256, 2, 1'b0);
    run_frame("empty", 0, 0, 1'b0);
    run_frame("partial", 300, 3, 1'b1);
    run_frame("wrap", 640, 5, 1'b1);

    // Overflow: DDR stalled, 520 beats into a 512-deep FIFO; last 8 must vanish.
    push_bursts(512);
    stall = 1'b1;
    start = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 520; i++) begin
      d = rand_word();
      vld = 1'b1;
      din = d;
      if (i < DEPTH) data_q.push_back(d);
      @(negedge clk);
      if (i == 128) chk("req_latency_early", req, 0);
      if (i == 129) chk("req_latency", req, 1);
    end
    vld = 1'b0;
    @(negedge clk);
`ifdef VIN_OVERFLOW_STAT_EN
    chk("ovf_cnt", ovf_cnt, 8);
    chk("ovf_flag", ovf_flag, 1);
`endif
    stall = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("ovf", 4);

    // Reset in the middle of a stalled burst.
    stall = 1'b1;
    start = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < BL; i++) begin
      vld = 1'b1;
      din = rand_word();
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_req_before_rst", req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_len", len, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_lines", lines, 0);
    chk("mid_rst_data", dout, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    run_frame("post_rst", 130, 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
